sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = master 1 always wins a tie.
REQ-002 SHALL have parameter TIMEOUT, default 255; the maximum number of BUSY cycles to wait for i_sram_ack.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_mN_req (N = 0, 1), input, 1 bit: transaction request, held high until o_mN_ack.
REQ-006 SHALL have port i_mN_wr, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port i_mN_addr, input, 18 bits: SRAM address.
REQ-008 SHALL have port i_mN_wdata, input, 32 bits: store data.
REQ-009 SHALL have port i_mN_bmask, input, 4 bits: byte lane enables.
REQ-010 SHALL have port o_mN_rdata, output, 32 bits: last read data returned to master N.
REQ-011 SHALL have port o_mN_ack, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port o_sram_addr, output, 18 bits: address to the 32-bit SRAM controller.
REQ-013 SHALL have port o_sram_wdata, output, 32 bits: write data to the controller.
REQ-014 SHALL have port o_sram_bmask, output, 4 bits: byte mask to the controller.
REQ-015 SHALL have port o_sram_wren, output, 1 bit: write strobe to the controller.
REQ-016 SHALL have port o_sram_rden, output, 1 bit: read strobe to the controller.
REQ-017 SHALL have port i_sram_rdata, input, 32 bits: read data from the controller.
REQ-018 SHALL have port i_sram_ack, input, 1 bit: controller done, level-valid.
REQ-019 SHALL have port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-020 SHALL have port o_timeout, output, 1 bit: sticky timeout flag.

Function
REQ-021 SHALL implement a three-state FSM: IDLE, BUSY, RELEASE.
REQ-022 In IDLE, if any i_mN_req is high, SHALL pick a winner, latch its wr/addr/wdata/bmask into internal registers, record the grant, clear the timeout counter, and go to BUSY the next cycle.
REQ-023 Arbitration: a single requester wins outright; on a tie with FIXED_PRIO=0, the master not granted last wins; on a tie with FIXED_PRIO=1, master 1 wins.
REQ-024 In BUSY, SHALL drive o_sram_addr/wdata/bmask from the latched registers and assert exactly one strobe: o_sram_wren if wr=1, else o_sram_rden.
REQ-025 Strobes SHALL be low in IDLE and RELEASE; o_sram_* data outputs SHALL hold the last latched values.
REQ-026 In BUSY with i_sram_ack=1: for a read, SHALL register i_sram_rdata into o_mN_rdata of the granted master; then pulse o_mN_ack for one cycle and go to RELEASE. Write completion SHALL leave o_mN_rdata unchanged.
REQ-027 RELEASE SHALL last exactly one cycle with strobes low (so the controller rearms), then return to IDLE.
REQ-028 Latency: request seen in IDLE at cycle t -> strobe at t+1; i_sram_ack first high at cycle t+k -> o_mN_ack and RELEASE at t+k+1 -> IDLE at t+k+2; next grant at t+k+2, strobe at t+k+3.
REQ-029 The timeout counter SHALL increment each BUSY cycle without ack; when it reaches TIMEOUT, SHALL pulse o_mN_ack with o_mN_rdata = 0, set o_timeout, and go to RELEASE.
REQ-030 o_timeout SHALL stay high until reset.
REQ-031 Ack and timeout in the same cycle: ack SHALL take precedence and o_timeout SHALL NOT set.
REQ-032 Latched request fields SHALL NOT change during BUSY; requester input changes or i_mN_req dropping mid-transaction SHALL be ignored, and the transaction SHALL complete with its ack pulse.
REQ-033 At most one o_mN_ack SHALL be high in any cycle, and only for the granted master.
REQ-034 i_sram_ack seen in IDLE or RELEASE SHALL be ignored.

Reset
REQ-035 On i_rst high at a clock edge: FSM to IDLE; strobes, acks and o_busy low; o_timeout cleared; counter 0; o_mN_rdata, o_sram_addr/wdata/bmask all 0; last-grant = master 1, so master 0 wins the first round-robin tie.
REQ-036 Reset asserted mid-BUSY SHALL abort the transaction with no ack issued.

Verification
REQ-037 m0 read, addr 0x00010, controller acks 3 cycles after strobe with rdata 0xDEADBEEF -> o_sram_rden high for 3 cycles, o_m0_rdata=0xDEADBEEF, one o_m0_ack pulse, one RELEASE cycle.
REQ-038 Both requesters held continuously, FIXED_PRIO=0 -> grants alternate m0, m1, m0, m1; never two consecutive grants to one master.
REQ-039 Same stimulus with FIXED_PRIO=1 -> m1 granted every time and m0 starves; m0 wins only after m1 drops req.
REQ-040 m1 write with bmask 0x4, TIMEOUT=8, controller never acks -> after 8 BUSY cycles o_m1_ack pulses, o_m1_rdata=0, o_timeout=1 and sticky until reset.
REQ-041 m0 read in BUSY, i_rst pulsed one cycle -> next cycle IDLE, strobes low, no o_m0_ack ever; a fresh m0 request afterwards completes normally.
REQ-042 m0 changes i_m0_addr and drops i_m0_req mid-BUSY -> o_sram_addr keeps the original address and the ack still pulses.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Bundle of the two master request ports, the SRAM controller port and the status flags.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface sram_arbiter_if;
    logic        i_m0_req;
    logic        i_m0_wr;
    logic [17:0] i_m0_addr;
    logic [31:0] i_m0_wdata;
    logic [3:0]  i_m0_bmask;
    logic [31:0] o_m0_rdata;
    logic        o_m0_ack;

    logic        i_m1_req;
    logic        i_m1_wr;
    logic [17:0] i_m1_addr;
    logic [31:0] i_m1_wdata;
    logic [3:0]  i_m1_bmask;
    logic [31:0] o_m1_rdata;
    logic        o_m1_ack;

    logic [17:0] o_sram_addr;
    logic [31:0] o_sram_wdata;
    logic [3:0]  o_sram_bmask;
    logic        o_sram_wren;
    logic        o_sram_rden;
    logic [31:0] i_sram_rdata;
    logic        i_sram_ack;

    logic        o_busy;
    logic        o_timeout;

    modport slave (
        input  i_m0_req, i_m0_wr, i_m0_addr, i_m0_wdata, i_m0_bmask,
        input  i_m1_req, i_m1_wr, i_m1_addr, i_m1_wdata, i_m1_bmask,
        input  i_sram_rdata, i_sram_ack,
        output o_m0_rdata, o_m0_ack, o_m1_rdata, o_m1_ack,
        output o_sram_addr, o_sram_wdata, o_sram_bmask, o_sram_wren, o_sram_rden,
        output o_busy, o_timeout
    );

    modport master (
        output i_m0_req, i_m0_wr, i_m0_addr, i_m0_wdata, i_m0_bmask,
        output i_m1_req, i_m1_wr, i_m1_addr, i_m1_wdata, i_m1_bmask,
        output i_sram_rdata, i_sram_ack,
        input  o_m0_rdata, o_m0_ack, o_m1_rdata, o_m1_ack,
        input  o_sram_addr, o_sram_wdata, o_sram_bmask, o_sram_wren, o_sram_rden,
        input  o_busy, o_timeout
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of a 32-bit SRAM controller (round-robin or fixed priority).
// Latency: strobe one cycle after grant; master ack one cycle after controller ack or timeout.
// Backpressure: masters hold req until their ack pulse; one RELEASE cycle separates transactions.
module sram_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    sram_arbiter_if.slave bus
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             wr_q, wr_d;
    logic [17:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       bmask_q, bmask_d;
    logic             grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      m0_rdata_q, m0_rdata_d;
    logic [31:0]      m1_rdata_q, m1_rdata_d;
    logic             m0_ack_q, m0_ack_d;
    logic             m1_ack_q, m1_ack_d;
    logic             timeout_q, timeout_d;

    logic any_req, pick, done_ack, done_to;

    // grant_q doubles as "last granted": on a round-robin tie the other master wins.
    always_comb begin
        any_req = bus.i_m0_req | bus.i_m1_req;
        if (bus.i_m0_req && bus.i_m1_req) begin
            pick = (FIXED_PRIO != 0) ? 1'b1 : ~grant_q;
        end else begin
            pick = bus.i_m1_req;
        end
        done_ack = (state_q == BUSY) && bus.i_sram_ack;
        done_to  = (state_q == BUSY) && !bus.i_sram_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            bmask_q    <= '0;
            grant_q    <= 1'b1;
            cnt_q      <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            bmask_q    <= bmask_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (done_ack || done_to) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bmask_d    = bmask_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        timeout_d  = timeout_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    wr_d    = pick ? bus.i_m1_wr    : bus.i_m0_wr;
                    addr_d  = pick ? bus.i_m1_addr  : bus.i_m0_addr;
                    wdata_d = pick ? bus.i_m1_wdata : bus.i_m0_wdata;
                    bmask_d = pick ? bus.i_m1_bmask : bus.i_m0_bmask;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done_ack || done_to) begin
                    if (grant_q) m1_ack_d = 1'b1;
                    else         m0_ack_d = 1'b1;
                end
                // A timed-out transaction returns zero data, even for a write.
                if (done_to) begin
                    timeout_d = 1'b1;
                    if (grant_q) m1_rdata_d = '0;
                    else         m0_rdata_d = '0;
                end else if (done_ack && !wr_q) begin
                    if (grant_q) m1_rdata_d = bus.i_sram_rdata;
                    else         m0_rdata_d = bus.i_sram_rdata;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.o_sram_wren = (state_q == BUSY) && wr_q;
        bus.o_sram_rden = (state_q == BUSY) && !wr_q;
        bus.o_busy      = (state_q != IDLE);
    end

    assign bus.o_sram_addr  = addr_q;
    assign bus.o_sram_wdata = wdata_q;
    assign bus.o_sram_bmask = bmask_q;
    assign bus.o_m0_rdata   = m0_rdata_q;
    assign bus.o_m1_rdata   = m1_rdata_q;
    assign bus.o_m0_ack     = m0_ack_q;
    assign bus.o_m1_ack     = m1_ack_q;
    assign bus.o_timeout    = timeout_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: dut_a is round-robin with a short timeout, dut_b is fixed-priority.
module tb_sram_arbiter;
    logic i_clk;
    logic i_rst;

    sram_arbiter_if ifa ();
    sram_arbiter_if ifb ();

    sram_arbiter #(.FIXED_PRIO(0), .TIMEOUT(8)) dut_a (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (ifa)
    );

    sram_arbiter #(.FIXED_PRIO(1), .TIMEOUT(8)) dut_b (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (ifb)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic        auto_a;
    logic        ack_a;
    logic [31:0] rdata_a;

    // In auto mode the controller model acks in the first strobe cycle.
    assign ifa.i_sram_ack   = auto_a ? (ifa.o_sram_rden | ifa.o_sram_wren) : ack_a;
    assign ifa.i_sram_rdata = rdata_a;
    assign ifb.i_sram_ack   = ifb.o_sram_rden | ifb.o_sram_wren;
    assign ifb.i_sram_rdata = 32'h0000_B0B0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ack(input bit use_b, output logic [1:0] who);
        who = 2'b00;
        for (int i = 0; i < 30; i++) begin
            tick();
            who = use_b ? {ifb.o_m1_ack, ifb.o_m0_ack} : {ifa.o_m1_ack, ifa.o_m0_ack};
            if (who != 2'b00) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] who;
        int         cyc;
        logic       seen;

        ifa.i_m0_req = 0; ifa.i_m0_wr = 0; ifa.i_m0_addr = '0; ifa.i_m0_wdata = '0; ifa.i_m0_bmask = 4'hF;
        ifa.i_m1_req = 0; ifa.i_m1_wr = 0; ifa.i_m1_addr = '0; ifa.i_m1_wdata = '0; ifa.i_m1_bmask = 4'hF;
        ifb.i_m0_req = 0; ifb.i_m0_wr = 0; ifb.i_m0_addr = 18'h00B00; ifb.i_m0_wdata = '0; ifb.i_m0_bmask = 4'hF;
        ifb.i_m1_req = 0; ifb.i_m1_wr = 0; ifb.i_m1_addr = 18'h00B01; ifb.i_m1_wdata = '0; ifb.i_m1_bmask = 4'hF;
        auto_a = 0; ack_a = 0; rdata_a = '0;

        // Reset values
        i_rst = 1;
        repeat (2) tick();
        chk("rst_busy",    ifa.o_busy, 0);
        chk("rst_strobe",  {ifa.o_sram_wren, ifa.o_sram_rden}, 0);
        chk("rst_acks",    {ifa.o_m1_ack, ifa.o_m0_ack}, 0);
        chk("rst_timeout", ifa.o_timeout, 0);
        chk("rst_rdata0",  ifa.o_m0_rdata, 0);
        chk("rst_addr",    ifa.o_sram_addr, 0);
        i_rst = 0;

        // Controller ack while idle is ignored
        ack_a = 1;
        tick(); tick();
        chk("idle_ack_ign", {ifa.o_busy, ifa.o_m1_ack, ifa.o_m0_ack}, 0);
        ack_a = 0;

        // m0 read, ack in the third strobe cycle
        ifa.i_m0_addr = 18'h00010; ifa.i_m0_wr = 0; ifa.i_m0_req = 1;
        cyc = 0;
        tick();
        chk("rd_strobe", {ifa.o_sram_wren, ifa.o_sram_rden}, 2'b01);
        chk("rd_addr",   ifa.o_sram_addr, 18'h00010);
        cyc += int'(ifa.o_sram_rden);
        tick(); cyc += int'(ifa.o_sram_rden);
        tick(); cyc += int'(ifa.o_sram_rden);
        ack_a = 1; rdata_a = 32'hDEADBEEF;
        tick();
        chk("rd_ack",     {ifa.o_m1_ack, ifa.o_m0_ack}, 2'b01);
        chk("rd_rdata",   ifa.o_m0_rdata, 32'hDEADBEEF);
        chk("rd_cycles",  cyc, 3);
        chk("rd_release", {ifa.o_busy, ifa.o_sram_rden, ifa.o_sram_wren}, 3'b100);
        ack_a = 0; ifa.i_m0_req = 0;
        tick();
        chk("rd_idle", {ifa.o_busy, ifa.o_m0_ack}, 0);

        // Ack arrives in the same cycle the timeout would fire
        ifa.i_m0_addr = 18'h00200; ifa.i_m0_req = 1;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cyc += int'(ifa.o_sram_rden);
        end
        ack_a = 1; rdata_a = 32'h0BADF00D;
        tick();
        chk("race_ack",   {ifa.o_m1_ack, ifa.o_m0_ack}, 2'b01);
        chk("race_rdata", ifa.o_m0_rdata, 32'h0BADF00D);
        chk("race_no_to", ifa.o_timeout, 0);
        chk("race_cyc",   cyc, 8);
        ack_a = 0; ifa.i_m0_req = 0;
        tick();

        // Requester changes fields and drops req mid-transaction
        ifa.i_m0_addr = 18'h00123; ifa.i_m0_req = 1;
        tick();
        ifa.i_m0_addr = 18'h2AAAA; ifa.i_m0_wr = 1; ifa.i_m0_req = 0;
        tick();
        chk("hold_addr", ifa.o_sram_addr, 18'h00123);
        chk("hold_rd",   {ifa.o_sram_wren, ifa.o_sram_rden}, 2'b01);
        ack_a = 1; rdata_a = 32'h55AA55AA;
        tick();
        chk("drop_ack",   {ifa.o_m1_ack, ifa.o_m0_ack}, 2'b01);
        chk("drop_rdata", ifa.o_m0_rdata, 32'h55AA55AA);
        ack_a = 0; ifa.i_m0_wr = 0;
        tick();

        // Reset restores last-grant = m1, so m0 wins the first tie
        i_rst = 1;
        tick();
        i_rst = 0;
        chk("rst_rdata_clr", ifa.o_m0_rdata, 0);

        // Round-robin with both masters held
        ifa.i_m0_addr = 18'h00001; ifa.i_m1_addr = 18'h00002;
        ifa.i_m0_wr = 0; ifa.i_m1_wr = 0;
        rdata_a = 32'hCAFE0001; auto_a = 1;
        ifa.i_m0_req = 1; ifa.i_m1_req = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(0, who);
            chk("rr_grant", who, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        ifa.i_m0_req = 0; ifa.i_m1_req = 0; auto_a = 0;
        tick(); tick();
        chk("rr_m1_rdata", ifa.o_m1_rdata, 32'hCAFE0001);

        // Fixed priority: m1 starves m0 until it lets go
        ifb.i_m0_req = 1; ifb.i_m1_req = 1;
        for (int k = 0; k < 3; k++) begin
            wait_ack(1, who);
            chk("fp_m1", who, 2'b10);
        end
        ifb.i_m1_req = 0;
        wait_ack(1, who);
        chk("fp_m0_after", who, 2'b01);
        ifb.i_m0_req = 0;

        // m1 write never acked -> timeout after 8 busy cycles
        ifa.i_m1_wr = 1; ifa.i_m1_addr = 18'h3FFFF; ifa.i_m1_wdata = 32'h12345678;
        ifa.i_m1_bmask = 4'h4; ifa.i_m1_req = 1;
        cyc = 0; who = 2'b00;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ({ifa.o_m1_ack, ifa.o_m0_ack} != 2'b00) begin
                who = {ifa.o_m1_ack, ifa.o_m0_ack};
                break;
            end
            if (ifa.o_sram_wren && ifa.o_sram_bmask == 4'h4) cyc++;
        end
        chk("to_cycles", cyc, 8);
        chk("to_ack",    who, 2'b10);
        chk("to_rdata",  ifa.o_m1_rdata, 0);
        chk("to_flag",   ifa.o_timeout, 1);
        ifa.i_m1_req = 0;
        repeat (3) tick();
        chk("to_sticky", {ifa.o_timeout, ifa.o_busy}, 2'b10);

        // Reset mid-BUSY aborts with no ack
        ifa.i_m0_addr = 18'h00777; ifa.i_m0_wr = 0; ifa.i_m0_req = 1;
        tick();
        chk("abort_pre", ifa.o_sram_rden, 1);
        i_rst = 1; ifa.i_m0_req = 0;
        tick();
        chk("abort_idle", {ifa.o_busy, ifa.o_sram_wren, ifa.o_sram_rden, ifa.o_m1_ack, ifa.o_m0_ack}, 0);
        chk("abort_to_clr", ifa.o_timeout, 0);
        i_rst = 0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | ifa.o_m0_ack | ifa.o_m1_ack;
        end
        chk("abort_no_ack", seen, 0);

        // Fresh request after the abort completes normally
        ifa.i_m0_addr = 18'h00778; ifa.i_m0_req = 1;
        tick();
        chk("fresh_addr", ifa.o_sram_addr, 18'h00778);
        ack_a = 1; rdata_a = 32'h600DCAFE;
        tick();
        chk("fresh_ack",   {ifa.o_m1_ack, ifa.o_m0_ack}, 2'b01);
        chk("fresh_rdata", ifa.o_m0_rdata, 32'h600DCAFE);
        ack_a = 0; ifa.i_m0_req = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
